// File: rtl/bcd_cascade_counter_pkg.sv
// Shared constants and helpers for the cascaded BCD/modulo counter.
package bcd_cascade_counter_pkg;

    // Every digit is stored in a nibble regardless of its modulus
    localparam int DIGIT_W = 4;

    // Legal parameter ranges
    localparam int NUM_DIGITS_MIN = 1;
    localparam int NUM_DIGITS_MAX = 8;
    localparam int DIGIT_MOD_MIN  = 2;
    localparam int DIGIT_MOD_MAX  = 16;

    // Per-edge action, encoded so a larger value means higher priority
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_EN   = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_CLR  = 2'd3
    } action_e;

    // Resolve the control strobes into the single action taken this edge
    function automatic action_e sel_action(input logic clr, input logic load, input logic en);
        if (clr)       return ACT_CLR;
        else if (load) return ACT_LOAD;
        else if (en)   return ACT_EN;
        else           return ACT_HOLD;
    endfunction

    // Clamp an out-of-range load nibble to the largest legal digit value
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] val, input int mod);
        if (int'(val) >= mod) return DIGIT_W'(mod - 1);
        else                  return val;
    endfunction

endpackage

// File: rtl/bcd_cascade_counter_digit.sv
// One digit of the cascade: modulo-DIGIT_MOD up/down register with clear/load.
module counter_digit
    import bcd_cascade_counter_pkg::*;
#(
    parameter int DIGIT_MOD = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_val,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_is_max,
    output logic               o_is_zero
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(DIGIT_MOD - 1);

    logic [DIGIT_W-1:0] r_digit;

    // Digit register: clear beats load beats inc/dec; wraps at both ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= sat_digit(i_load_val, DIGIT_MOD);
        end else if (i_inc) begin
            r_digit <= (r_digit == MAX_VAL) ? '0 : r_digit + DIGIT_W'(1);
        end else if (i_dec) begin
            r_digit <= (r_digit == '0) ? MAX_VAL : r_digit - DIGIT_W'(1);
        end
    end

    assign o_digit   = r_digit;
    assign o_is_max  = (r_digit == MAX_VAL);
    assign o_is_zero = (r_digit == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded modulo counter: NUM_DIGITS digit cells chained by carry/borrow
// prefixes, with a registered wrap pulse (cout) and sticky wrap flag (ovf).
module bcd_cascade_counter
    import bcd_cascade_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_MOD  = 10
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          clr,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] cnt,
    output logic                          tc,
    output logic                          cout,
    output logic                          ovf
);

    action_e                               w_act;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    w_load_val;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    w_digits;
    logic [NUM_DIGITS-1:0]                 w_is_max;
    logic [NUM_DIGITS-1:0]                 w_is_zero;
    logic [NUM_DIGITS:0]                   w_up_pfx;
    logic [NUM_DIGITS:0]                   w_dn_pfx;
    logic [NUM_DIGITS-1:0]                 w_inc;
    logic [NUM_DIGITS-1:0]                 w_dec;
    logic                                  w_step;
    logic                                  r_cout;
    logic                                  r_ovf;

    assign w_act      = sel_action(clr, load, en);
    assign w_step     = (w_act == ACT_EN);
    assign w_load_val = load_val;

    // w_up_pfx[k] / w_dn_pfx[k]: all digits below k are at max / zero
    assign w_up_pfx[0] = 1'b1;
    assign w_dn_pfx[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign w_up_pfx[k+1] = w_up_pfx[k] & w_is_max[k];
        assign w_dn_pfx[k+1] = w_dn_pfx[k] & w_is_zero[k];
        assign w_inc[k]      = w_step &  up_dn & w_up_pfx[k];
        assign w_dec[k]      = w_step & ~up_dn & w_dn_pfx[k];

        counter_digit #(
            .DIGIT_MOD (DIGIT_MOD)
        ) u_digit (
            .clk        (clk),
            .rstn       (rstn),
            .i_clr      (clr),
            .i_load     (load),
            .i_load_val (w_load_val[k]),
            .i_inc      (w_inc[k]),
            .i_dec      (w_dec[k]),
            .o_digit    (w_digits[k]),
            .o_is_max   (w_is_max[k]),
            .o_is_zero  (w_is_zero[k])
        );
    end

    // Terminal count looks only at en/direction, never at clr/load
    assign tc = en & (up_dn ? w_up_pfx[NUM_DIGITS] : w_dn_pfx[NUM_DIGITS]);

    // Wrap pulse and sticky flag; only a real count step at tc can wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (w_act)
                ACT_CLR: begin
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end
                ACT_EN: begin
                    r_cout <= tc;
                    if (tc) r_ovf <= 1'b1;
                end
                default: begin
                    r_cout <= 1'b0;
                end
            endcase
        end
    end

    assign cnt  = w_digits;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed bench: 2-digit decimal counter plus a 1-digit modulo-2 instance.
module tb_bcd_cascade_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: NUM_DIGITS=2, DIGIT_MOD=10
    logic       rstn, en, up_dn, clr, load;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic       tc, cout, ovf;

    // Second DUT: NUM_DIGITS=1, DIGIT_MOD=2
    logic       b_rstn, b_en, b_up_dn, b_clr, b_load;
    logic [3:0] b_load_val;
    logic [3:0] b_cnt;
    logic       b_tc, b_cout, b_ovf;

    int errs   = 0;
    int checks = 0;

    bcd_cascade_counter #(.NUM_DIGITS(2), .DIGIT_MOD(10)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt), .tc(tc), .cout(cout), .ovf(ovf)
    );

    bcd_cascade_counter #(.NUM_DIGITS(1), .DIGIT_MOD(2)) u_dut_b (
        .clk(clk), .rstn(b_rstn), .en(b_en), .up_dn(b_up_dn), .clr(b_clr), .load(b_load),
        .load_val(b_load_val), .cnt(b_cnt), .tc(b_tc), .cout(b_cout), .ovf(b_ovf)
    );

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Advance one edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [7:0] v);
        clr = c; load = l; en = e; up_dn = u; load_val = v;
        #0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; b_rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        b_en = 1'b0; b_up_dn = 1'b1; b_clr = 1'b0; b_load = 1'b0; b_load_val = 4'h0;
        #12;
        checks++; if (cnt !== 8'h00) begin errs++; $display("FAIL reset_cnt: got %h want 00", cnt); end
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (tc !== 1'b0) begin errs++; $display("FAIL reset_tc_en0: got %b want 0", tc); end
        checks++; if (b_cnt !== 4'h0) begin errs++; $display("FAIL reset_b_cnt: got %h want 0", b_cnt); end
        rstn = 1'b1; b_rstn = 1'b1;
    endtask

    task automatic test_up_wrap();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        tick();
        checks++; if (cnt !== 8'h98) begin errs++; $display("FAIL upw_load: got %h want 98", cnt); end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        #1;
        checks++; if (tc !== 1'b0) begin errs++; $display("FAIL upw_tc98: got %b want 0", tc); end
        tick();
        checks++; if (cnt !== 8'h99) begin errs++; $display("FAIL upw_99: got %h want 99", cnt); end
        checks++; if (tc !== 1'b1) begin errs++; $display("FAIL upw_tc99: got %b want 1", tc); end
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL upw_cout99: got %b want 0", cout); end
        tick();
        checks++; if (cnt !== 8'h00) begin errs++; $display("FAIL upw_00: got %h want 00", cnt); end
        checks++; if (cout !== 1'b1) begin errs++; $display("FAIL upw_cout: got %b want 1", cout); end
        checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL upw_ovf: got %b want 1", ovf); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL upw_cout_one: got %b want 0", cout); end
        checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL upw_ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_down_wrap();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        checks++; if (cnt !== 8'h00) begin errs++; $display("FAIL dnw_clr: got %h want 00", cnt); end
        checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL dnw_clr_ovf: got %b want 0", ovf); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        #1;
        checks++; if (tc !== 1'b1) begin errs++; $display("FAIL dnw_tc: got %b want 1", tc); end
        tick();
        checks++; if (cnt !== 8'h99) begin errs++; $display("FAIL dnw_99: got %h want 99", cnt); end
        checks++; if (cout !== 1'b1) begin errs++; $display("FAIL dnw_cout: got %b want 1", cout); end
        checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL dnw_ovf: got %b want 1", ovf); end
        tick();
        checks++; if (cnt !== 8'h98) begin errs++; $display("FAIL dnw_98: got %h want 98", cnt); end
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL dnw_cout98: got %b want 0", cout); end
    endtask

    task automatic test_priority();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        tick();
        checks++; if (cnt !== 8'h00) begin errs++; $display("FAIL pri_clr_cnt: got %h want 00", cnt); end
        checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL pri_clr_ovf: got %b want 0", ovf); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hFC);
        tick();
        checks++; if (cnt !== 8'h99) begin errs++; $display("FAIL pri_sat: got %h want 99", cnt); end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        #1;
        checks++; if (tc !== 1'b1) begin errs++; $display("FAIL pri_tc_load: got %b want 1", tc); end
        tick();
        checks++; if (cnt !== 8'h99) begin errs++; $display("FAIL pri_load_en: got %h want 99", cnt); end
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL pri_load_cout: got %b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL pri_load_ovf: got %b want 0", ovf); end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        checks++; if (cout !== 1'b1) begin errs++; $display("FAIL pri_wrap_cout: got %b want 1", cout); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h3A);
        tick();
        checks++; if (cnt !== 8'h39) begin errs++; $display("FAIL pri_sat_lo: got %h want 39", cnt); end
        checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL pri_load_keeps_ovf: got %b want 1", ovf); end
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL pri_load_cout2: got %b want 0", cout); end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cnt !== 8'h39 || cout !== 1'b0 || ovf !== 1'b1) begin
                errs++; $display("FAIL hold_%0d: got cnt=%h cout=%b ovf=%b want 39/0/1", i, cnt, cout, ovf);
            end
        end
    endtask

    task automatic test_dir_change();
        logic [7:0] exp_seq [4];
        logic       dir_seq [4];
        exp_seq = '{8'h06, 8'h05, 8'h04, 8'h05};
        dir_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, dir_seq[i], 8'h00);
            tick();
            checks++; if (cnt !== exp_seq[i]) begin
                errs++; $display("FAIL dir_%0d: got %h want %h", i, cnt, exp_seq[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int n_cout;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        n_cout = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (cout === 1'b1) n_cout++;
            checks++; if (cnt !== bcd(i % 100)) begin
                errs++; $display("FAIL sweep_up_%0d: got %h want %h", i, cnt, bcd(i % 100));
            end
        end
        checks++; if (n_cout != 1) begin errs++; $display("FAIL sweep_up_couts: got %0d want 1", n_cout); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        n_cout = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (cout === 1'b1) n_cout++;
            checks++; if (cnt !== bcd((100 - i) % 100)) begin
                errs++; $display("FAIL sweep_dn_%0d: got %h want %h", i, cnt, bcd((100 - i) % 100));
            end
        end
        checks++; if (n_cout != 1) begin errs++; $display("FAIL sweep_dn_couts: got %0d want 1", n_cout); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h56);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        checks++; if (cnt !== 8'h57) begin errs++; $display("FAIL ar_pre: got %h want 57", cnt); end
        checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ar_pre_ovf: got %b want 1", ovf); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (cnt !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            errs++; $display("FAIL ar_async: got cnt=%h cout=%b ovf=%b want 00/0/0", cnt, cout, ovf);
        end
        #1 rstn = 1'b1;
        tick();
        checks++; if (cnt !== 8'h01) begin errs++; $display("FAIL ar_resume: got %h want 01", cnt); end
        checks++; if (cout !== 1'b0) begin errs++; $display("FAIL ar_resume_cout: got %b want 0", cout); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cnt [4];
        logic       exp_co  [4];
        exp_cnt = '{4'h1, 4'h0, 4'h1, 4'h0};
        exp_co  = '{1'b0, 1'b1, 1'b0, 1'b1};
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0; b_en = 1'b1; b_up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (b_cnt !== exp_cnt[i] || b_cout !== exp_co[i]) begin
                errs++; $display("FAIL b_toggle_%0d: got cnt=%h cout=%b want %h/%b", i, b_cnt, b_cout, exp_cnt[i], exp_co[i]);
            end
        end
        // At 0 counting down, then at 1 counting up: every edge wraps
        b_up_dn = 1'b0;
        #1;
        checks++; if (b_tc !== 1'b1) begin errs++; $display("FAIL b_tc_dn: got %b want 1", b_tc); end
        tick();
        checks++; if (b_cnt !== 4'h1 || b_cout !== 1'b1) begin
            errs++; $display("FAIL b_b2b_0: got cnt=%h cout=%b want 1/1", b_cnt, b_cout);
        end
        b_up_dn = 1'b1;
        tick();
        checks++; if (b_cnt !== 4'h0 || b_cout !== 1'b1 || b_ovf !== 1'b1) begin
            errs++; $display("FAIL b_b2b_1: got cnt=%h cout=%b ovf=%b want 0/1/1", b_cnt, b_cout, b_ovf);
        end
        b_en = 1'b0;
        tick();
        checks++; if (b_cout !== 1'b0) begin errs++; $display("FAIL b_idle_cout: got %b want 0", b_cout); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority();
        test_hold();
        test_dir_change();
        test_sweep();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 Parameter NUM_DIGITS SHALL be provided: default 4; number of cascaded digits, legal range 1..8.
REQ-002 Parameter DIGIT_MOD SHALL be provided: default 10; modulus of every digit, legal range 2..16.
REQ-003 Port clk SHALL be an input of width 1: clock; all state changes on the rising edge.
REQ-004 Port rstn SHALL be an input of width 1: reset, asynchronous, active-low.
REQ-005 Port en SHALL be an input of width 1: count enable.
REQ-006 Port up_dn SHALL be an input of width 1: count direction; 1 = up, 0 = down.
REQ-007 Port clr SHALL be an input of width 1: synchronous clear.
REQ-008 Port load SHALL be an input of width 1: synchronous load strobe.
REQ-009 Port load_val SHALL be an input of width NUM_DIGITS*4: load value; digit k occupies bits [4k+3:4k].
REQ-010 Port cnt SHALL be an output of width NUM_DIGITS*4: registered count, packed with the same layout as load_val.
REQ-011 Port tc SHALL be an output of width 1: combinational terminal count.
REQ-012 Port cout SHALL be an output of width 1: registered one-cycle wrap pulse.
REQ-013 Port ovf SHALL be an output of width 1: sticky wrap flag.

Function
REQ-014 Each rising edge SHALL apply exactly one action, with priority clr > load > en > hold.
REQ-015 clr=1 SHALL set every digit to 0, clear ovf and drive cout to 0 on the next cycle.
REQ-016 load=1 SHALL write each digit from load_val; any digit value >= DIGIT_MOD SHALL be saturated to DIGIT_MOD-1; cout SHALL be 0 and ovf SHALL be unchanged.
REQ-017 With en=1 and up_dn=1, digit 0 SHALL increment; digit k (k>0) SHALL increment only when digits 0..k-1 all equal DIGIT_MOD-1; a digit at DIGIT_MOD-1 that increments SHALL wrap to 0.
REQ-018 With en=1 and up_dn=0, digit 0 SHALL decrement; digit k (k>0) SHALL decrement only when digits 0..k-1 all equal 0; a digit at 0 that decrements SHALL wrap to DIGIT_MOD-1.
REQ-019 tc SHALL equal en & (up_dn ? all digits == DIGIT_MOD-1 : all digits == 0), with no dependence on clr or load.
REQ-020 On an edge where the count advances while tc=1 and clr=load=0, cout SHALL be 1 during the following cycle (the cycle cnt first shows the wrapped value) and ovf SHALL be set.
REQ-021 cout SHALL be 0 in every other cycle; consecutive wraps (NUM_DIGITS=1, DIGIT_MOD=2) SHALL yield back-to-back pulses.
REQ-022 A change of up_dn between edges SHALL take effect on the next edge with no extra latency or lost count.
REQ-023 With en=0 and clr=load=0, cnt and ovf SHALL hold and cout SHALL be 0.
REQ-024 Latency SHALL be 1 clock from sampled control inputs to cnt, cout and ovf.

Reset
REQ-025 rstn=0 SHALL immediately force every digit of cnt to 0 and force cout and ovf to 0, independent of clk.
REQ-026 Reset asserted mid-count SHALL discard any pending increment, decrement or cout, and the first edge after deassertion SHALL act on inputs as in REQ-014.

Structure
REQ-027 A shared package SHALL hold DIGIT_W = 4, the legal ranges of NUM_DIGITS and DIGIT_MOD, and the priority-encoding constants for clr, load, en and hold.
REQ-028 The design SHALL use one sub-module, counter_digit, which holds one digit register with inputs inc, dec, clr, load and load value, and outputs the digit value plus is_max and is_zero.
REQ-029 The top level SHALL generate NUM_DIGITS instances of counter_digit and form the carry/borrow chain as AND-prefixes of the is_max / is_zero outputs.
REQ-030 The top level SHALL hold the cout and ovf registers.

Verification (NUM_DIGITS=2, DIGIT_MOD=10 unless noted)
REQ-031 Up wrap: load 0x98, then en=1, up_dn=1 for 2 cycles -> cnt 0x99 with tc=1, then cnt 0x00, cout=1 for exactly one cycle, ovf=1.
REQ-032 Down wrap: clr, then en=1, up_dn=0 -> cnt 0x99, cout pulse and ovf=1; the next edge -> 0x98, cout=0.
REQ-033 Priority and saturation: clr=1, load=1, en=1 together -> cnt 0x00 and ovf=0; load 0xFC alone -> cnt 0x99.
REQ-034 Full sweep: 100 up counts from 0x00 -> every BCD value visited once in order, exactly one cout pulse; 100 down counts behave the same in reverse order.
REQ-035 Async reset: at cnt 0x57 with en=1, rstn pulsed low between edges -> cnt 0x00, cout=0, ovf=0 immediately; counting resumes from 0x01 after deassertion.
REQ-036 Parameter sweep: NUM_DIGITS=1, DIGIT_MOD=2, en held 1 -> cnt toggles 0,1,0,1 and cout pulses on every return to 0.
